nmea_sentence_receiver: RTL and testbench
=========================================

Name: nmea_sentence_receiver

Overview:
Generalised NMEA-0183 sentence receiver. It replaces fixed per-field receivers with one variable-length field splitter.
- Matches "$" + parametrised sentence prefix + separator.
- Streams every comma-separated field (any count up to MAX_FIELDS, any length up to FIELD_W bytes) on a per-field strobe.
- Verifies the XOR checksum and reports a coded error.
- Sits between the UART byte receiver and sentence-specific decoders (ZDA, RMC, GGA).

Parameters:
- B, 8, bits per byte
- PREFIX_LEN, 5, prefix length in bytes, excluding "$" and separator
- PREFIX, "GPZDA", expected talker+sentence id, PREFIX_LEN*B bits
- SEPARATOR, ",", field separator byte
- MAX_FIELDS, 8, maximum fields per sentence (>=1)
- FIELD_W, 10, maximum bytes per field (>=1)

Ports:
- clock  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high reset
- load  in  1  data valid this cycle
- data  in  B  received byte
- field_valid  out  1  one-cycle strobe: field_index/field_len/field_data valid
- field_index  out  $clog2(MAX_FIELDS)  0-based field number
- field_len  out  $clog2(FIELD_W+1)  bytes in field, 0 for empty field
- field_data  out  FIELD_W*B  field bytes, last-received byte in [0+:B], unused upper bytes zero
- resolve  out  1  one-cycle strobe: sentence finished (ok or error)
- error  out  1  valid with resolve; 1 = sentence rejected
- error_code  out  3  valid with resolve; see Behaviour
- field_count  out  $clog2(MAX_FIELDS+1)  fields emitted in this sentence, valid with resolve

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset (any time, including mid-sentence): state=S_Idle; buffer, checksum and counters cleared; all outputs 0.
- Cycles with load=0 change nothing. All strobes are registered: they pulse exactly one cycle after the load that caused them.
- State machine:
  - S_Idle: "$" -> S_Prefix; other bytes ignored.
  - S_Prefix: compares PREFIX then SEPARATOR byte by byte.
    - Mismatch -> S_Idle silently (no resolve; sentence belongs to another decoder).
    - "$" restarts prefix matching.
    - Full match -> S_Field, field_index=0.
  - S_Field: bytes other than SEPARATOR/"*"/"$" append to the buffer.
    - SEPARATOR or "*" terminates the field: field_valid pulses, then buffer clears and index increments.
    - "*" also -> S_Check.
  - S_Check: exactly two hex digits. Accepted: 0-9, A-F, a-f. First digit is the high nibble. Second digit -> compare, resolve.
- Checksum: XOR of every byte after "$" up to but excluding "*"; includes the prefix and all separators. B bits wide.
- Error codes (error=1 for codes 1-6; first error wins):
  - 0 OK
  - 1 FIELD_OVERFLOW: (FIELD_W+1)-th byte of a field
  - 2 TOO_MANY_FIELDS: terminator arriving when field_count==MAX_FIELDS; no field_valid for it
  - 3 BAD_HEX: non-hex checksum digit
  - 4 CHECKSUM: digits parse but mismatch
  - 5 ABORTED: "$" in S_Field/S_Check
  - 6 BAD_TERM: only with the optional feature
- On codes 1-4 and 6: resolve+error pulse immediately, then S_Idle.
- On code 5: resolve+error pulse, and the "$" starts a new sentence (-> S_Prefix, checksum cleared) in the same cycle.
- Fields already emitted before an error are not retracted; downstream discards them on error.
- Two consecutive terminators yield an empty field (field_len=0, field_data=0).

Optional Feature:
- NMEA_CRLF_EN defined:
  - After the second checksum digit, go to S_Term, expecting CR then LF.
  - resolve pulses one cycle after LF.
  - Any other byte gives error_code 6; "$" gives error_code 5 plus restart.
  - Checksum errors are reported at the second digit, without waiting for CR/LF.
- Undefined: resolve pulses one cycle after the second checksum digit; trailing bytes are ignored in S_Idle.

Decomposition:
- Package nmea_pkg: error-code constants, state encoding, ASCII constants ("$", "*", CR, LF), and a hex-digit decode function.
- Sub-module nmea_field_buffer (sequential): shift-in byte register with length counter, clear, and overflow flag. Holds FIELD_W bytes.

Test Plan:
- "$GPZDA,1,2*4B" -> field_valid (idx0, len1, 0x31), then (idx1, len1, 0x32); resolve, error=0, field_count=2. Same with "*4b" -> identical.
- "$GPZDA,,*48" -> two empty fields (len 0); resolve OK, field_count=2.
- "$GPZDA,1,2*4C" -> resolve, error=1, code 4. "$GPZDA,1,2*4G" -> code 3.
- 11-char field with FIELD_W=10 -> resolve code 1 one cycle after the 11th byte; no field_valid for that field.
- "$GPZDA,12$GPZDA,1,2*4B" -> resolve code 5 after the second "$", then a clean second sentence resolves OK. "$GPRMC,1*00" -> no strobes at all. Reset asserted mid-field -> no strobes; the next sentence parses OK.
- With NMEA_CRLF_EN: "$GPZDA,1,2*4B\r\n" -> resolve OK after LF; "...*4BX" -> code 6.

Source files
------------

// File: rtl/nmea_pkg.sv
// nmea_pkg: shared constants for the NMEA sentence receiver.
// Holds FSM state encodings, error codes, ASCII framing characters and a
// hex-digit decoder used for the two-character checksum trailer.
package nmea_pkg;

    // FSM state encoding
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PREFIX = 3'd1;
    localparam logic [2:0] S_FIELD  = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_TERM   = 3'd4;

    // Error codes reported with resolve
    localparam logic [2:0] ERR_OK              = 3'd0;
    localparam logic [2:0] ERR_FIELD_OVERFLOW  = 3'd1;
    localparam logic [2:0] ERR_TOO_MANY_FIELDS = 3'd2;
    localparam logic [2:0] ERR_BAD_HEX         = 3'd3;
    localparam logic [2:0] ERR_CHECKSUM        = 3'd4;
    localparam logic [2:0] ERR_ABORTED         = 3'd5;
    localparam logic [2:0] ERR_BAD_TERM        = 3'd6;

    // ASCII framing characters
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;

    // Returns {valid, nibble}; accepts 0-9, A-F, a-f.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) begin
            return {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            return {1'b1, c[3:0] + 4'd9};
        end else begin
            return 5'b0_0000;
        end
    endfunction

endpackage

// File: rtl/nmea_field_buffer.sv
// nmea_field_buffer: collects the bytes of one field.
// Each pushed byte shifts in at the bottom (last byte in [0+:B]); unused upper
// bytes stay zero. A push while already holding FIELD_W bytes is not stored
// and raises o_overflow for that cycle.
module nmea_field_buffer #(
    parameter int unsigned B       = 8,
    parameter int unsigned FIELD_W = 10,
    parameter int unsigned LEN_W   = $clog2(FIELD_W + 1)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_push,
    input  logic [B-1:0]         i_byte,
    output logic [LEN_W-1:0]     o_len,
    output logic [FIELD_W*B-1:0] o_data,
    output logic                 o_overflow
);

    localparam int unsigned DW = FIELD_W * B;

    logic [LEN_W-1:0] r_len;
    logic [DW-1:0]    r_data;
    logic             w_full;
    logic [DW-1:0]    w_byte_ext;

    assign w_full     = (r_len == LEN_W'(FIELD_W));
    assign w_byte_ext = DW'(i_byte);

    // Shift-in storage with length counter; clear has priority over push
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_len  <= '0;
            r_data <= '0;
        end else if (i_push && !w_full) begin
            r_data <= (r_data << B) | w_byte_ext;
            r_len  <= r_len + LEN_W'(1);
        end
    end

    assign o_len      = r_len;
    assign o_data     = r_data;
    assign o_overflow = i_push && w_full;

endmodule

// File: rtl/nmea_sentence_receiver.sv
// nmea_sentence_receiver: matches "$"+PREFIX+SEPARATOR, streams each
// comma-separated field on a one-cycle strobe, verifies the XOR checksum
// and reports the sentence outcome with a coded error.
// Optional feature macro: NMEA_CRLF_EN (require CR LF after the checksum).
module nmea_sentence_receiver
    import nmea_pkg::*;
#(
    parameter int unsigned             B          = 8,
    parameter int unsigned             PREFIX_LEN = 5,
    parameter logic [PREFIX_LEN*B-1:0] PREFIX     = "GPZDA",
    parameter logic [B-1:0]            SEPARATOR  = ",",
    parameter int unsigned             MAX_FIELDS = 8,
    parameter int unsigned             FIELD_W    = 10,
    localparam int unsigned            IDX_W      = (MAX_FIELDS > 1) ? $clog2(MAX_FIELDS) : 1,
    localparam int unsigned            LEN_W      = $clog2(FIELD_W + 1),
    localparam int unsigned            CNT_W      = $clog2(MAX_FIELDS + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [B-1:0]         data,
    output logic                 field_valid,
    output logic [IDX_W-1:0]     field_index,
    output logic [LEN_W-1:0]     field_len,
    output logic [FIELD_W*B-1:0] field_data,
    output logic                 resolve,
    output logic                 error,
    output logic [2:0]           error_code,
    output logic [CNT_W-1:0]     field_count
);

    localparam int unsigned      PIDX_W  = $clog2(PREFIX_LEN + 1);
    localparam logic [PIDX_W-1:0] PFX_DONE = PIDX_W'(PREFIX_LEN);
    localparam logic [CNT_W-1:0]  FC_MAX   = CNT_W'(MAX_FIELDS);

    // FSM and sentence state
    logic [2:0]        r_state,  w_state_n;
    logic [PIDX_W-1:0] r_pidx,   w_pidx_n;
    logic [B-1:0]      r_csum,   w_csum_n;
    logic [CNT_W-1:0]  r_fcount, w_fcount_n;
    logic [3:0]        r_hi,     w_hi_n;
    logic              r_digit,  w_digit_n;
`ifdef NMEA_CRLF_EN
    logic              r_lf,     w_lf_n;
`endif

    // Registered outputs
    logic                 r_field_valid;
    logic [IDX_W-1:0]     r_field_index;
    logic [LEN_W-1:0]     r_field_len;
    logic [FIELD_W*B-1:0] r_field_data;
    logic                 r_resolve;
    logic                 r_error;
    logic [2:0]           r_error_code;
    logic [CNT_W-1:0]     r_field_count;

    // Byte classification and helpers
    logic [7:0]           w_byte;
    logic                 w_is_dollar, w_is_star, w_is_sep;
    logic [4:0]           w_hex;
    logic [B-1:0]         w_rx_sum;
    logic [B-1:0]         w_pfx_byte;
    logic                 w_fld_fire, w_res_fire;
    logic [2:0]           w_res_code;

    // Field buffer interface
    logic                 w_buf_push, w_buf_clear, w_buf_ovf;
    logic [LEN_W-1:0]     w_buf_len;
    logic [FIELD_W*B-1:0] w_buf_data;

    assign w_byte      = data[7:0];
    assign w_is_dollar = (w_byte == CH_DOLLAR);
    assign w_is_star   = (w_byte == CH_STAR);
    assign w_is_sep    = (data == SEPARATOR);
    assign w_hex       = hex_decode(w_byte);
    assign w_rx_sum    = B'({r_hi, w_hex[3:0]});

    // Payload bytes go into the buffer; every other loaded byte empties it
    assign w_buf_push  = load && (r_state == S_FIELD) && !w_is_dollar && !w_is_sep && !w_is_star;
    assign w_buf_clear = load && !w_buf_push;

    nmea_field_buffer #(
        .B       (B),
        .FIELD_W (FIELD_W),
        .LEN_W   (LEN_W)
    ) u_buf (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_clear    (w_buf_clear),
        .i_push     (w_buf_push),
        .i_byte     (data),
        .o_len      (w_buf_len),
        .o_data     (w_buf_data),
        .o_overflow (w_buf_ovf)
    );

    // Select the prefix byte expected at the current match position
    always_comb begin
        w_pfx_byte = '0;
        for (int unsigned k = 0; k < PREFIX_LEN; k++) begin
            if (r_pidx == PIDX_W'(k)) begin
                w_pfx_byte = PREFIX[(PREFIX_LEN - 1 - k) * B +: B];
            end
        end
    end

    // Next-state, checksum and strobe decisions for the current byte
    always_comb begin
        w_state_n  = r_state;
        w_pidx_n   = r_pidx;
        w_csum_n   = r_csum;
        w_fcount_n = r_fcount;
        w_hi_n     = r_hi;
        w_digit_n  = r_digit;
`ifdef NMEA_CRLF_EN
        w_lf_n     = r_lf;
`endif
        w_fld_fire = 1'b0;
        w_res_fire = 1'b0;
        w_res_code = ERR_OK;
        if (load) begin
            // "$" is handled once for all states: it always restarts prefix
            // matching, and aborts the sentence if one was being parsed.
            if (w_is_dollar) begin
                if (r_state == S_FIELD || r_state == S_CHECK || r_state == S_TERM) begin
                    w_res_fire = 1'b1;
                    w_res_code = ERR_ABORTED;
                end
                w_state_n  = S_PREFIX;
                w_pidx_n   = '0;
                w_csum_n   = '0;
                w_fcount_n = '0;
                w_digit_n  = 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                    end
                    S_PREFIX: begin
                        if (r_pidx != PFX_DONE) begin
                            if (data == w_pfx_byte) begin
                                w_pidx_n = r_pidx + PIDX_W'(1);
                                w_csum_n = r_csum ^ data;
                            end else begin
                                w_state_n = S_IDLE;
                            end
                        end else if (w_is_sep) begin
                            w_state_n  = S_FIELD;
                            w_csum_n   = r_csum ^ data;
                            w_fcount_n = '0;
                        end else begin
                            w_state_n = S_IDLE;
                        end
                    end
                    S_FIELD: begin
                        if (w_is_sep || w_is_star) begin
                            if (r_fcount == FC_MAX) begin
                                w_res_fire = 1'b1;
                                w_res_code = ERR_TOO_MANY_FIELDS;
                                w_state_n  = S_IDLE;
                            end else begin
                                w_fld_fire = 1'b1;
                                w_fcount_n = r_fcount + CNT_W'(1);
                                if (w_is_star) begin
                                    w_state_n = S_CHECK;
                                    w_digit_n = 1'b0;
                                end else begin
                                    w_csum_n = r_csum ^ data;
                                end
                            end
                        end else if (w_buf_ovf) begin
                            w_res_fire = 1'b1;
                            w_res_code = ERR_FIELD_OVERFLOW;
                            w_state_n  = S_IDLE;
                        end else begin
                            w_csum_n = r_csum ^ data;
                        end
                    end
                    S_CHECK: begin
                        if (!w_hex[4]) begin
                            w_res_fire = 1'b1;
                            w_res_code = ERR_BAD_HEX;
                            w_state_n  = S_IDLE;
                        end else if (!r_digit) begin
                            w_hi_n    = w_hex[3:0];
                            w_digit_n = 1'b1;
                        end else if (w_rx_sum != r_csum) begin
                            w_res_fire = 1'b1;
                            w_res_code = ERR_CHECKSUM;
                            w_state_n  = S_IDLE;
                        end else begin
`ifdef NMEA_CRLF_EN
                            w_state_n = S_TERM;
                            w_lf_n    = 1'b0;
`else
                            w_res_fire = 1'b1;
                            w_res_code = ERR_OK;
                            w_state_n  = S_IDLE;
`endif
                        end
                    end
`ifdef NMEA_CRLF_EN
                    S_TERM: begin
                        if (!r_lf && w_byte == CH_CR) begin
                            w_lf_n = 1'b1;
                        end else if (r_lf && w_byte == CH_LF) begin
                            w_res_fire = 1'b1;
                            w_res_code = ERR_OK;
                            w_state_n  = S_IDLE;
                        end else begin
                            w_res_fire = 1'b1;
                            w_res_code = ERR_BAD_TERM;
                            w_state_n  = S_IDLE;
                        end
                    end
`endif
                    default: begin
                        w_state_n = S_IDLE;
                    end
                endcase
            end
        end
    end

    // Sentence state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_pidx   <= '0;
            r_csum   <= '0;
            r_fcount <= '0;
            r_hi     <= '0;
            r_digit  <= 1'b0;
`ifdef NMEA_CRLF_EN
            r_lf     <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_n;
            r_pidx   <= w_pidx_n;
            r_csum   <= w_csum_n;
            r_fcount <= w_fcount_n;
            r_hi     <= w_hi_n;
            r_digit  <= w_digit_n;
`ifdef NMEA_CRLF_EN
            r_lf     <= w_lf_n;
`endif
        end
    end

    // Output strobes and the values that accompany them
    always_ff @(posedge clock) begin
        if (reset) begin
            r_field_valid <= 1'b0;
            r_field_index <= '0;
            r_field_len   <= '0;
            r_field_data  <= '0;
            r_resolve     <= 1'b0;
            r_error       <= 1'b0;
            r_error_code  <= '0;
            r_field_count <= '0;
        end else begin
            r_field_valid <= w_fld_fire;
            if (w_fld_fire) begin
                r_field_index <= r_fcount[IDX_W-1:0];
                r_field_len   <= w_buf_len;
                r_field_data  <= w_buf_data;
            end
            r_resolve <= w_res_fire;
            if (w_res_fire) begin
                r_error       <= (w_res_code != ERR_OK);
                r_error_code  <= w_res_code;
                r_field_count <= r_fcount;
            end
        end
    end

    assign field_valid = r_field_valid;
    assign field_index = r_field_index;
    assign field_len   = r_field_len;
    assign field_data  = r_field_data;
    assign resolve     = r_resolve;
    assign error       = r_error;
    assign error_code  = r_error_code;
    assign field_count = r_field_count;

endmodule

// File: tb/tb_nmea_sentence_receiver.sv
// tb_nmea_sentence_receiver: directed and randomized sentences for
// nmea_sentence_receiver. Expected strobes are derived from how each
// sentence was constructed (field list, XOR of the text, injected fault).
module tb_nmea_sentence_receiver;

    localparam int unsigned B          = 8;
    localparam int unsigned PREFIX_LEN = 5;
    localparam int unsigned MAX_FIELDS = 8;
    localparam int unsigned FIELD_W    = 10;
    localparam int unsigned DW         = FIELD_W * B;
    localparam int unsigned IDX_W      = $clog2(MAX_FIELDS);
    localparam int unsigned LEN_W      = $clog2(FIELD_W + 1);
    localparam int unsigned CNT_W      = $clog2(MAX_FIELDS + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             load  = 1'b0;
    logic [B-1:0]     data  = '0;
    logic             field_valid;
    logic [IDX_W-1:0] field_index;
    logic [LEN_W-1:0] field_len;
    logic [DW-1:0]    field_data;
    logic             resolve;
    logic             error;
    logic [2:0]       error_code;
    logic [CNT_W-1:0] field_count;

    nmea_sentence_receiver #(
        .B          (B),
        .PREFIX_LEN (PREFIX_LEN),
        .PREFIX     ("GPZDA"),
        .SEPARATOR  (8'h2C),
        .MAX_FIELDS (MAX_FIELDS),
        .FIELD_W    (FIELD_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .data        (data),
        .field_valid (field_valid),
        .field_index (field_index),
        .field_len   (field_len),
        .field_data  (field_data),
        .resolve     (resolve),
        .error       (error),
        .error_code  (error_code),
        .field_count (field_count)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // cyc: observed cycle, or (in expectations) index of the triggering byte
    typedef struct {
        int unsigned cyc;
        bit          is_res;
        int unsigned idx;
        int unsigned len;
        logic [DW-1:0] dat;
        logic        err;
        logic [2:0]  code;
        int unsigned cnt;
    } ev_t;

    ev_t         obs_q[$];
    ev_t         exp_q[$];
    logic [7:0]  tx[$];
    int unsigned sent_cyc[$];
    int          errors = 0;
    int          checks = 0;

    function automatic ev_t mk_ev(int unsigned c, bit r, int unsigned i, int unsigned l,
                                  logic [DW-1:0] d, logic e, logic [2:0] cd, int unsigned n);
        ev_t x;
        x.cyc = c; x.is_res = r; x.idx = i; x.len = l;
        x.dat = d; x.err = e; x.code = cd; x.cnt = n;
        return x;
    endfunction

    always @(negedge clock) begin
        if (field_valid)
            obs_q.push_back(mk_ev(cyc, 1'b0, field_index, field_len, field_data, 1'b0, 3'd0, 0));
        if (resolve)
            obs_q.push_back(mk_ev(cyc, 1'b1, 0, 0, '0, error, error_code, field_count));
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) tx.push_back(s[i]);
    endtask

    task automatic ef(input int unsigned pos, input int unsigned idx, input string s);
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < s.len(); i++) d = (d << 8) | DW'(s[i]);
        exp_q.push_back(mk_ev(pos, 1'b0, idx, s.len(), d, 1'b0, 3'd0, 0));
    endtask

    task automatic er(input int unsigned pos, input int unsigned code, input int unsigned cnt);
        exp_q.push_back(mk_ev(pos, 1'b1, 0, 0, '0, code != 0, code[2:0], cnt));
    endtask

    // A good sentence ends at its second checksum digit, or after CR LF
    task automatic ok_tail(input int unsigned pos, input int unsigned cnt);
`ifdef NMEA_CRLF_EN
        tx.push_back(8'h0D);
        tx.push_back(8'h0A);
        er(pos + 2, 0, cnt);
`else
        er(pos, 0, cnt);
`endif
    endtask

    function automatic logic [7:0] hexch(input logic [3:0] n, input bit lower);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return (lower ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, " field_valid"}, field_valid, 0);
        chk({tag, " field_index"}, field_index, 0);
        chk({tag, " field_len"},   field_len,   0);
        chk({tag, " field_data"},  field_data,  0);
        chk({tag, " resolve"},     resolve,     0);
        chk({tag, " error"},       error,       0);
        chk({tag, " error_code"},  error_code,  0);
        chk({tag, " field_count"}, field_count, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        load  = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Feed tx, then compare every observed strobe with the expectations
    task automatic run(input string tag, input bit gaps);
        int unsigned n;
        obs_q.delete();
        sent_cyc.delete();
        foreach (tx[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(negedge clock);
                load = 1'b0;
            end
            @(negedge clock);
            load = 1'b1;
            data = tx[i];
            sent_cyc.push_back(cyc);
        end
        @(negedge clock);
        load = 1'b0;
        repeat (3) @(negedge clock);
        chk({tag, " event_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++) begin
            chk({tag, " kind"},  obs_q[i].is_res, exp_q[i].is_res);
            chk({tag, " cycle"}, obs_q[i].cyc, sent_cyc[exp_q[i].cyc] + 1);
            if (exp_q[i].is_res) begin
                chk({tag, " error"},       obs_q[i].err,  exp_q[i].err);
                chk({tag, " error_code"},  obs_q[i].code, exp_q[i].code);
                chk({tag, " field_count"}, obs_q[i].cnt,  exp_q[i].cnt);
            end else begin
                chk({tag, " field_index"}, obs_q[i].idx, exp_q[i].idx);
                chk({tag, " field_len"},   obs_q[i].len, exp_q[i].len);
                chk({tag, " field_data"},  obs_q[i].dat, exp_q[i].dat);
            end
        end
        exp_q.delete();
        tx.delete();
    endtask

    // mode: 0 good, 1 wrong checksum, 2 field overflow, 3 too many fields, 4 bad hex
    task automatic gen_random(input int unsigned mode);
        logic [7:0]    cs, sent, ch, hi_c, lo_c;
        logic [7:0]    bad [6];
        logic [DW-1:0] d;
        int unsigned   nf, ovf_i, len;
        bit            lower;
        bad = '{8'h47, 8'h67, 8'h3A, 8'h2F, 8'h40, 8'h5A};
        push_str("$GPZDA,");
        cs = 8'h47 ^ 8'h50 ^ 8'h5A ^ 8'h44 ^ 8'h41 ^ 8'h2C;
        nf    = (mode == 3) ? MAX_FIELDS + 1 : $urandom_range(1, MAX_FIELDS);
        ovf_i = $urandom_range(0, nf - 1);
        for (int unsigned i = 0; i < nf; i++) begin
            len = (mode == 2 && i == ovf_i) ? FIELD_W + 1 : $urandom_range(0, FIELD_W);
            d = '0;
            for (int unsigned j = 0; j < len; j++) begin
                ch = 8'($urandom_range(8'h30, 8'h5A));
                tx.push_back(ch);
                cs ^= ch;
                d = (d << 8) | DW'(ch);
                if (j == FIELD_W) begin
                    er(tx.size() - 1, 1, i);
                    return;
                end
            end
            tx.push_back((i == nf - 1) ? 8'h2A : 8'h2C);
            if (i == MAX_FIELDS) begin
                er(tx.size() - 1, 2, MAX_FIELDS);
                return;
            end
            exp_q.push_back(mk_ev(tx.size() - 1, 1'b0, i, len, d, 1'b0, 3'd0, 0));
            if (i != nf - 1) cs ^= 8'h2C;
        end
        sent = (mode == 1) ? (cs ^ 8'($urandom_range(1, 255))) : cs;
        lower = 1'($urandom_range(0, 1));
        hi_c = hexch(sent[7:4], lower);
        lo_c = hexch(sent[3:0], lower);
        if (mode == 4) begin
            if ($urandom_range(0, 1) == 1) begin
                tx.push_back(bad[$urandom_range(0, 5)]);
            end else begin
                tx.push_back(hi_c);
                tx.push_back(bad[$urandom_range(0, 5)]);
            end
            er(tx.size() - 1, 3, nf);
            return;
        end
        tx.push_back(hi_c);
        tx.push_back(lo_c);
        if (mode == 1) er(tx.size() - 1, 4, nf);
        else ok_tail(tx.size() - 1, nf);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_outputs_zero("reset");

        push_str("$GPZDA,1,2*4B");
        ef(8, 0, "1"); ef(10, 1, "2"); ok_tail(12, 2);
        run("basic_upper", 1'b0);

        push_str("$GPZDA,1,2*4b");
        ef(8, 0, "1"); ef(10, 1, "2"); ok_tail(12, 2);
        run("basic_lower", 1'b0);

        push_str("$GPZDA,,*48");
        ef(7, 0, ""); ef(8, 1, ""); ok_tail(10, 2);
        run("empty_fields", 1'b0);

        push_str("$GPZDA,1,2*4C");
        ef(8, 0, "1"); ef(10, 1, "2"); er(12, 4, 2);
        run("bad_checksum", 1'b0);

        push_str("$GPZDA,1,2*4G");
        ef(8, 0, "1"); ef(10, 1, "2"); er(12, 3, 2);
        run("bad_hex", 1'b0);

        push_str("$GPZDA,12345678901*00");
        er(17, 1, 0);
        run("overflow", 1'b0);

        push_str("$GPZDA,12$GPZDA,1,2*4B");
        er(9, 5, 0); ef(17, 0, "1"); ef(19, 1, "2"); ok_tail(21, 2);
        run("abort_field", 1'b0);

        push_str("$GPZDA,1*$GPZDA,1,2*4B");
        ef(8, 0, "1"); er(9, 5, 1); ef(17, 0, "1"); ef(19, 1, "2"); ok_tail(21, 2);
        run("abort_check", 1'b0);

        push_str("$$GPZDA,1,2*4B");
        ef(9, 0, "1"); ef(11, 1, "2"); ok_tail(13, 2);
        run("prefix_restart", 1'b0);

        push_str("$GPRMC,1*00");
        run("other_sentence", 1'b0);

        push_str("$GPZDA,1,2*4BX");
        ef(8, 0, "1"); ef(10, 1, "2");
`ifdef NMEA_CRLF_EN
        er(13, 6, 2);
`else
        er(12, 0, 2);
`endif
        run("trailing_byte", 1'b0);

        push_str("$GPZDA,12");
        run("pre_reset", 1'b0);
        do_reset();
        check_outputs_zero("mid_reset");
        push_str("$GPZDA,1,2*4B");
        ef(8, 0, "1"); ef(10, 1, "2"); ok_tail(12, 2);
        run("after_reset", 1'b0);

        for (int unsigned k = 0; k < 40; k++) begin
            gen_random(k % 5);
            run($sformatf("rnd%0d_m%0d", k, k % 5), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
